// File: rtl/aes_key_sched_ctrl.sv
// AES-128/AES-256 key expansion sequencer sharing one external g_function
// (RotWord+SubWord+Rcon, one-cycle latency); emits one round key per valid pulse.
module aes_key_sched_ctrl (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_key_256,
  input  logic [255:0] i_key_in,
  output logic [31:0]  o_g_word,
  output logic [7:0]   o_g_rcon,
  input  logic [31:0]  i_g_result,
  output logic [127:0] o_round_key,
  output logic [3:0]   o_round_key_idx,
  output logic         o_round_key_valid,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic [1:0] {S_IDLE, S_KEY1, S_ISSUE, S_COMPUTE} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_m256;
  logic [127:0] r_cur, r_prev, r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_idx;
  logic         r_vld, r_busy, r_done;

  logic         w_accept, w_hstep, w_last;
  logic [3:0]   w_idx_nxt;
  logic [31:0]  w_w, w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_base, w_new;
  logic [7:0]   w_rcon_nxt;

  // done is high in the first IDLE cycle; a start there must be ignored
  assign w_accept   = (r_state == S_IDLE) & i_start & ~r_done;
  // AES-256 steps into an odd index use SubWord only
  assign w_hstep    = r_m256 & ~r_idx[0];
  assign w_idx_nxt  = r_idx + 4'd1;
  assign w_last     = (w_idx_nxt == (r_m256 ? 4'd14 : 4'd10));
  assign w_w        = r_cur[31:0];
  assign w_base     = r_m256 ? r_prev : r_cur;
  assign w_n0       = w_base[127:96] ^ i_g_result;
  assign w_n1       = w_base[95:64]  ^ w_n0;
  assign w_n2       = w_base[63:32]  ^ w_n1;
  assign w_n3       = w_base[31:0]   ^ w_n2;
  assign w_new      = {w_n0, w_n1, w_n2, w_n3};
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_g_word    = 32'h0;
    o_g_rcon    = 8'h0;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = i_key_256 ? S_KEY1 : S_ISSUE;
      S_KEY1:    w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_state_nxt = S_COMPUTE;
        // pre-rotate right so the g_function's left rotation cancels out
        o_g_word    = w_hstep ? {w_w[7:0], w_w[31:8]} : w_w;
        o_g_rcon    = w_hstep ? 8'h00 : r_rcon;
      end
      S_COMPUTE: w_state_nxt = w_last ? S_IDLE : S_ISSUE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m256 <= 1'b0;
      r_cur  <= '0;
      r_prev <= '0;
      r_rk   <= '0;
      r_rcon <= 8'h01;
      r_idx  <= 4'd0;
      r_vld  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= w_accept;
          if (w_accept) begin
            r_m256 <= i_key_256;
            r_cur  <= i_key_in[255:128];
            r_prev <= '0;
            r_rcon <= 8'h01;
            r_rk   <= i_key_in[255:128];
            r_idx  <= 4'd0;
            r_vld  <= 1'b1;
          end
        end
        S_KEY1: begin
          r_prev <= r_cur;
          r_cur  <= i_key_in[127:0];
          r_rk   <= i_key_in[127:0];
          r_idx  <= 4'd1;
          r_vld  <= 1'b1;
        end
        S_COMPUTE: begin
          if (r_m256) r_prev <= r_cur;
          r_cur  <= w_new;
          r_rk   <= w_new;
          r_idx  <= w_idx_nxt;
          r_vld  <= 1'b1;
          if (!w_hstep) r_rcon <= w_rcon_nxt;
          if (w_last)   r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_round_key       = r_rk;
  assign o_round_key_idx   = r_idx;
  assign o_round_key_valid = r_vld;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule
